// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states and update helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package branch_predictor_pkg;

    // 2-bit saturating counter states; bit 1 is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Value every entry takes after reset or clear.
    localparam ctr_e CTR_INIT = WNT;

    // Saturating step towards the resolved outcome.
    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = ctr_e'(cur + 2'd1);
            end
        end else begin
            if (cur != SNT) begin
                nxt = ctr_e'(cur - 2'd1);
            end
        end
        return nxt;
    endfunction

    // Starting state for a freshly allocated (re-tagged) entry.
    function automatic ctr_e ctr_alloc(input logic taken);
        return taken ? WT : WNT;
    endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// Counter table (optional partial tags under BP_TAG_EN) with same-cycle update-to-lookup forwarding.
// Latency: lookup result is combinational; table writes land on the next rising clk edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lk_pc_i,
    input  logic        upd_vld_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic        clear_i,
    output logic        lk_taken_o
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] lk_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                fwd;
    ctr_e                upd_ctr_d;
    ctr_e                lk_ctr;
    logic                lk_hit;

    ctr_e                ctr_q [DEPTH];

    // Only the index (and tag) fields of the PCs matter; the rest is deliberately dropped.
    logic                unused_pc;
    assign unused_pc = ^{lk_pc_i, upd_pc_i};

    assign lk_idx  = lk_pc_i[IDX_BITS+1:2];
    assign upd_idx = upd_pc_i[IDX_BITS+1:2];
    assign fwd     = upd_vld_i && (upd_idx == lk_idx);

`ifdef BP_TAG_EN
    logic [TAG_BITS-1:0] lk_tag;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic                lk_vld;
    logic [TAG_BITS-1:0] lk_tag_seen;

    logic [TAG_BITS-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;

    assign lk_tag  = lk_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign upd_tag = upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // New counter value for the update slot: train on a tag hit, otherwise re-allocate.
    always_comb begin
        upd_hit   = vld_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_ctr_d = upd_hit ? ctr_update(ctr_q[upd_idx], upd_taken_i) : ctr_alloc(upd_taken_i);
    end

    // Lookup sees the post-update entry when both target the same slot.
    always_comb begin
        lk_ctr      = fwd ? upd_ctr_d : ctr_q[lk_idx];
        lk_vld      = fwd ? 1'b1      : vld_q[lk_idx];
        lk_tag_seen = fwd ? upd_tag   : tag_q[lk_idx];
        lk_hit      = lk_vld && (lk_tag_seen == lk_tag);
    end

    // Tag and valid storage; clear drops all valid bits and wins over an update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (clear_i) begin
            vld_q <= '0;
        end else if (upd_vld_i) begin
            vld_q[upd_idx] <= 1'b1;
            tag_q[upd_idx] <= upd_tag;
        end
    end
`else
    // Tag width only has meaning in the tagged build.
    logic [TAG_BITS-1:0] unused_tag;
    assign unused_tag = '0;

    // New counter value for the update slot.
    always_comb begin
        upd_ctr_d = ctr_update(ctr_q[upd_idx], upd_taken_i);
    end

    // Lookup sees the post-update counter when both target the same slot.
    always_comb begin
        lk_ctr = fwd ? upd_ctr_d : ctr_q[lk_idx];
        lk_hit = 1'b1;
    end
`endif

    // A lookup during clear always reads not-taken.
    assign lk_taken_o = !clear_i && lk_hit && lk_ctr[1];

    // Counter storage; clear reinitialises every entry and takes priority over an update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_vld_i) begin
            ctr_q[upd_idx] <= upd_ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter table, registered prediction, branch/mispredict statistics (BP_TAG_EN adds partial tags).
// Latency: pred_valid/pred_taken one cycle after lookup; updates and statistics take effect on the same edge.
// Backpressure: none; lookup and update are accepted every cycle, pred_taken holds while lookup_valid=0.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_mispredict,
    input  logic        clear,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    logic        tbl_taken;

    logic        pred_valid_q;
    logic        pred_valid_d;
    logic        pred_taken_q;
    logic        pred_taken_d;
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    bp_table #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .lk_pc_i     (lookup_pc),
        .upd_vld_i   (upd_valid),
        .upd_pc_i    (upd_pc),
        .upd_taken_i (upd_taken),
        .clear_i     (clear),
        .lk_taken_o  (tbl_taken)
    );

    // Next-state for the prediction register and the wrapping statistics counters.
    always_comb begin
        pred_valid_d       = lookup_valid;
        pred_taken_d       = pred_taken_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (lookup_valid) begin
            pred_taken_d = tbl_taken;
        end
        if (upd_valid) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid_q       <= 1'b0;
            pred_taken_q       <= 1'b0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            pred_valid_q       <= pred_valid_d;
            pred_taken_q       <= pred_taken_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized plus directed bench for branch_predictor against a table-level reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: n/a (the DUT accepts every cycle).
module tb_branch_predictor;

    localparam int IDX_BITS = 5;
    localparam int TAG_BITS = 8;
    localparam int DEPTH    = 1 << IDX_BITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int          m_ctr [DEPTH];
    bit          m_vld [DEPTH];
    int          m_tag [DEPTH];
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic        m_pv;
    logic        m_pt;

    always #5 clk = ~clk;

    branch_predictor #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .clear            (clear),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (IDX_BITS + 2)) % (1 << TAG_BITS));
    endfunction

    function automatic void m_init_table();
        for (int i = 0; i < DEPTH; i++) begin
            m_ctr[i] = 1;
            m_vld[i] = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        m_init_table();
        for (int i = 0; i < DEPTH; i++) m_tag[i] = 0;
        m_br  = '0;
        m_mis = '0;
        m_pv  = 1'b0;
        m_pt  = 1'b0;
    endfunction

    function automatic bit m_predict(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
`ifdef BP_TAG_EN
        if (!m_vld[i] || m_tag[i] != tag_of(pc)) return 1'b0;
`endif
        return m_ctr[i] >= 2;
    endfunction

    function automatic void m_train(input logic [31:0] pc, input bit taken);
        int i;
        i = idx_of(pc);
`ifdef BP_TAG_EN
        if (!m_vld[i] || m_tag[i] != tag_of(pc)) begin
            m_vld[i] = 1'b1;
            m_tag[i] = tag_of(pc);
            m_ctr[i] = taken ? 2 : 1;
            return;
        end
`endif
        if (taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        else       m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare all outputs.
    task automatic step(input string name, input bit lv, input logic [31:0] lpc,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input bit um, input bit clr);
        lookup_valid   = lv;
        lookup_pc      = lpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_mispredict = um;
        clear          = clr;
        @(posedge clk);
        if (uv) begin
            m_br = m_br + 32'd1;
            if (um) m_mis = m_mis + 32'd1;
            if (!clr) m_train(upc, ut);
        end
        if (lv) m_pt = clr ? 1'b0 : m_predict(lpc);
        m_pv = lv;
        if (clr) m_init_table();
        #1;
        check({name, ".pred_valid"}, {31'd0, pred_valid}, {31'd0, m_pv});
        check({name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, m_pt});
        check({name, ".branches"}, stat_branches, m_br);
        check({name, ".mispredicts"}, stat_mispredicts, m_mis);
    endtask

    task automatic upd(input string name, input logic [31:0] pc, input bit taken, input bit mis);
        step(name, 1'b0, 32'h0, 1'b1, pc, taken, mis, 1'b0);
    endtask

    task automatic look(input string name, input logic [31:0] pc);
        step(name, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_reset();

        // Asynchronous reset with activity on the inputs: nothing may be accepted.
        #1 rst = 1'b0;
        #2;
        check("rst_async.pred_valid", {31'd0, pred_valid}, 32'd0);
        check("rst_async.pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_async.branches", stat_branches, 32'd0);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h1000;
        upd_valid    = 1'b1;
        upd_pc       = 32'h1000;
        upd_taken    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_held.pred_valid", {31'd0, pred_valid}, 32'd0);
        check("rst_held.branches", stat_branches, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First lookup after reset reads the weak-not-taken default.
        look("rst_first", 32'h1000);
        check("rst_first.taken_const", {31'd0, pred_taken}, 32'd0);

        // Training, saturation and un-training.
        upd("train1", 32'h1000, 1'b1, 1'b1);
        upd("train2", 32'h1000, 1'b1, 1'b0);
        look("train_look", 32'h1000);
        check("train_look.taken_const", {31'd0, pred_taken}, 32'd1);
        upd("train3", 32'h1000, 1'b1, 1'b0);
        upd("untrain1", 32'h1000, 1'b0, 1'b1);
        look("sat_look", 32'h1000);
        upd("untrain2", 32'h1000, 1'b0, 1'b1);
        look("untrain_look", 32'h1000);
        check("untrain_look.taken_const", {31'd0, pred_taken}, 32'd0);

        // Hold while lookup_valid is low.
        upd("hold_train", 32'h1000, 1'b1, 1'b0);
        look("hold_look", 32'h1000);
        step("hold_idle", 1'b0, 32'h1000, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0);

        // Same-cycle update and lookup at 0x2004 (counter 01) forward the new value.
        step("fwd", 1'b1, 32'h2004, 1'b1, 32'h2004, 1'b1, 1'b0, 1'b0);
        check("fwd.taken_const", {31'd0, pred_taken}, 32'd1);

        // Clear beats a simultaneous taken update; statistics still count it.
        upd("clr_pre", 32'h1000, 1'b1, 1'b0);
        step("clr", 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 1'b1, 1'b1);
        look("clr_after", 32'h1000);
        check("clr_after.taken_const", {31'd0, pred_taken}, 32'd0);

`ifdef BP_TAG_EN
        // Tag aliasing: 0x1000 and 0x1080 share an index but not a tag.
        upd("tag_t1", 32'h1000, 1'b1, 1'b0);
        upd("tag_t2", 32'h1000, 1'b1, 1'b0);
        look("tag_own", 32'h1000);
        look("tag_alias", 32'h1080);
        check("tag_alias.taken_const", {31'd0, pred_taken}, 32'd0);
        upd("tag_alloc", 32'h1080, 1'b1, 1'b0);
        look("tag_new", 32'h1080);
        check("tag_new.taken_const", {31'd0, pred_taken}, 32'd1);
        look("tag_old", 32'h1000);
        check("tag_old.taken_const", {31'd0, pred_taken}, 32'd0);
`endif

        // Randomized traffic with deliberate index collisions and forwarding.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lpc;
            logic [31:0] upc;
            lpc = $urandom & 32'h0000_03FC;
            upc = ($urandom_range(0, 3) == 0) ? lpc : ($urandom & 32'h0000_03FC);
            step("rand", 1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 2) != 0),
                 upc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0));
        end

        // Mid-update asynchronous reset discards the pending update.
        lookup_valid = 1'b1;
        upd_valid    = 1'b1;
        upd_pc       = 32'h1000;
        upd_taken    = 1'b1;
        #2 rst = 1'b0;
        #1;
        m_reset();
        check("rst_mid.pred_valid", {31'd0, pred_valid}, 32'd0);
        check("rst_mid.pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_mid.branches", stat_branches, 32'd0);
        check("rst_mid.mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Statistics: five branches, two mispredicted.
        upd("st1", 32'h0040, 1'b1, 1'b0);
        upd("st2", 32'h0044, 1'b0, 1'b1);
        upd("st3", 32'h0048, 1'b1, 1'b0);
        upd("st4", 32'h004C, 1'b0, 1'b1);
        upd("st5", 32'h0050, 1'b1, 1'b0);
        check("stat.branches_const", stat_branches, 32'd5);
        check("stat.mispredicts_const", stat_mispredicts, 32'd2);

        // Wrap of the branch counter from all-ones.
        upd_valid = 1'b0;
        force dut.stat_branches_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches_q;
        m_br = 32'hFFFF_FFFF;
        upd("wrap", 32'h0040, 1'b1, 1'b0);
        check("wrap.branches_const", stat_branches, 32'd0);

        step("tail", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("FAIL timeout: got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 5: the table holds 2^IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
REQ-002 SHALL have parameter TAG_BITS, default 8: partial-tag width, used only when BP_TAG_EN is defined.
REQ-003 SHALL have one clock, clk: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have lookup_valid  input  1  fetch-stage lookup request.
REQ-006 SHALL have lookup_pc  input  32  PC of the instruction being fetched.
REQ-007 SHALL have pred_valid  output  1  registered lookup_valid.
REQ-008 SHALL have pred_taken  output  1  prediction for the previous cycle's lookup_pc.
REQ-009 SHALL have upd_valid  input  1  execute stage resolved a conditional branch this cycle.
REQ-010 SHALL have upd_pc  input  32  PC of the resolved branch.
REQ-011 SHALL have upd_taken  input  1  actual outcome (br_taken).
REQ-012 SHALL have upd_mispredict  input  1  prediction was wrong (inverse of br_pred_correct).
REQ-013 SHALL have clear  input  1  synchronous request to reinitialise all table state.
REQ-014 SHALL have stat_branches  output  32  count of resolved branches.
REQ-015 SHALL have stat_mispredicts  output  32  count of mispredictions.

Function
REQ-016 SHALL keep one 2-bit saturating counter per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 SHALL register pred_taken exactly one cycle after lookup, as counter[1] of the indexed entry; the output SHALL hold its value while lookup_valid=0.
REQ-018 SHALL, when upd_valid=1, increment the counter at upd index if upd_taken=1 (saturating at 11), otherwise decrement it (saturating at 00), writing on the same clock edge.
REQ-019 SHALL, when a lookup and an update hit the same index in the same cycle, base pred_taken on the post-update counter value (forwarding).
REQ-020 SHALL, on upd_valid=1, increment stat_branches, and SHALL also increment stat_mispredicts when upd_mispredict=1; both SHALL wrap modulo 2^32.
REQ-021 SHALL ignore upd_taken, upd_mispredict and upd_pc when upd_valid=0.
REQ-022 SHALL, when clear=1, set every counter to 01 on the next edge; clear takes priority over a simultaneous update, and the statistics counters are not affected.
REQ-023 SHALL give any lookup in a clear cycle pred_taken=0.
REQ-024 SHALL have no state machine beyond the table itself; the design is a single-stage read/modify/write with one-cycle read latency.

Reset
REQ-025 SHALL, on rst=0, immediately set all counters to 01, all tags/valid bits to 0, pred_valid=0, pred_taken=0, stat_branches=0 and stat_mispredicts=0, independent of clk.
REQ-026 SHALL, when reset is asserted mid-update, discard that update, and SHALL accept no lookup or update until the first edge after rst is released.

Configuration
REQ-027 SHALL, with BP_TAG_EN defined, store a valid bit and TAG_BITS tag bits per entry; a lookup whose tag (pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]) mismatches, or whose entry is invalid, SHALL predict not-taken.
REQ-028 SHALL, with BP_TAG_EN defined, treat an update whose tag mismatches as an allocation: write the tag, set valid=1, and initialise the counter to 10 if upd_taken=1, otherwise 01.
REQ-029 SHALL, with BP_TAG_EN defined, clear valid bits on clear.
REQ-030 SHALL, without BP_TAG_EN, have no tag storage; behaviour is REQ-016 to REQ-024 only.

Structure
REQ-031 SHALL place the counter-state constants (SNT/WNT/WT/ST) and the saturating-update function in the shared core package.
REQ-032 SHALL implement the table plus forwarding logic as one sub-module, bp_table; the counters and port registration SHALL live in the top.

Verification
REQ-033 SHALL cover reset: rst=0 then release, lookup pc=0x1000 -> pred_valid=1, pred_taken=0 the next cycle.
REQ-034 SHALL cover training: two updates pc=0x1000 taken, then lookup 0x1000 -> pred_taken=1; a third taken update leaves the counter at 11; two not-taken updates -> pred_taken=0.
REQ-035 SHALL cover forwarding: counter at 01, same-cycle update 0x2004 taken and lookup 0x2004 -> pred_taken=1.
REQ-036 SHALL cover statistics: 5 updates with 2 having upd_mispredict=1 -> stat_branches=5, stat_mispredicts=2; counter preloaded to 0xFFFFFFFF plus 1 update -> 0.
REQ-037 SHALL cover clear priority: clear=1 together with a taken update to a trained entry -> counter=01 and statistics still incremented.
REQ-038 SHALL cover tag aliasing with BP_TAG_EN and IDX_BITS=5: train 0x1000 to taken, then lookup 0x1080 (same index, different tag) -> pred_taken=0; a taken update at 0x1080 allocates it, so 0x1080 -> 1 and 0x1000 -> 0.
